// File: rtl/mxu_pkg.sv
// Shared types and cache map for the mxu host driver and its read port.
package mxu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CYC,
    WR_DATA,
    WR_START,
    POLL,
    READ
  } state_e;

  localparam int unsigned AXW = 32;
  localparam int unsigned WDW = 9;
  localparam int unsigned RDW = 32;

  localparam int unsigned ADDR_STATUS    = 0;
  localparam int unsigned ADDR_CYCLES    = 1;
  localparam int unsigned ADDR_DATA_BASE = 2;

  localparam logic [7:0]  STATUS_START    = 8'h01;
  localparam int unsigned STATUS_DONE_BIT = 1;

endpackage

// File: rtl/mxu_rd_port.sv
// Single outstanding read: arready pulse, fixed latency, rready on the sample cycle.
module mxu_rd_port
  import mxu_pkg::*;
#(
  parameter int unsigned READ_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_i,
  input  logic [AXW-1:0] addr_i,
  output logic           arready_o,
  output logic [AXW-1:0] araddr_o,
  output logic           rready_o,
  input  logic [RDW-1:0] rdata_i,
  output logic           ack_c,
  output logic [RDW-1:0] data_c
);

  localparam int unsigned CW = $clog2(READ_LAT + 1);

  logic           pend_q;
  logic [CW-1:0]  cnt_q;
  logic           arready_q;
  logic           rready_q;
  logic [AXW-1:0] araddr_q;

  // cnt_q holds the cycles left until the rready cycle, counted from the arready cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= 1'b0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
    end else begin
      arready_q <= 1'b0;
      rready_q  <= 1'b0;
      if (req_i && !pend_q && !rready_q) begin
        pend_q    <= 1'b1;
        cnt_q     <= CW'(READ_LAT - 1);
        arready_q <= 1'b1;
        araddr_q  <= addr_i;
      end else if (pend_q) begin
        if (cnt_q == '0) begin
          rready_q <= 1'b1;
          pend_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign arready_o = arready_q;
  assign araddr_o  = araddr_q;
  assign rready_o  = rready_q;
  assign ack_c     = rready_q;
  assign data_c    = rdata_i;

endmodule

// File: rtl/mxu_host_driver.sv
// Runs one mxu job: write cycles, operands and start, poll status, stream results out.
module mxu_host_driver
  import mxu_pkg::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [7:0]     start_cycles,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RDW-1:0] out_data,
  output logic           out_last,
  output logic           busy,
  output logic           timeout,
  output logic           job_done,
  output logic [AXW-1:0] awaddr,
  output logic [WDW-1:0] wdata,
  output logic           wready,
  output logic [AXW-1:0] araddr,
  output logic           arready,
  output logic           rready,
  input  logic [RDW-1:0] rdata
);

  localparam int unsigned NOPS = 2 * SIZE * SIZE;
  localparam int unsigned NRES = SIZE * SIZE;
  localparam int unsigned KW   = $clog2(NOPS + 1);
  localparam int unsigned JW   = $clog2(NRES + 1);
  localparam int unsigned PW   = $clog2(MAX_POLLS + 1);
  localparam int unsigned GW   = $clog2(POLL_GAP + 1);

  state_e         state_q;
  logic [KW-1:0]  k_q;
  logic [JW-1:0]  j_q;
  logic [PW-1:0]  p_q;
  logic [GW-1:0]  gap_q;
  logic           rd_pend_q;
  logic           start_ready_q, in_ready_q, busy_q;
  logic           wready_q;
  logic [AXW-1:0] awaddr_q;
  logic [WDW-1:0] wdata_q;
  logic           out_valid_q, out_last_q, job_done_q, timeout_q;
  logic [RDW-1:0] out_data_q;

  logic           rd_req_c;
  logic [AXW-1:0] rd_addr_c;
  logic           rd_ack_c;
  logic [RDW-1:0] rd_data_c;
  logic           out_hs_c;

  assign out_hs_c = out_valid_q && out_ready;

  // Next result read is launched in the handshake cycle so it starts without a bubble
  always_comb begin
    rd_req_c  = 1'b0;
    rd_addr_c = AXW'(ADDR_STATUS);
    if (state_q == POLL) begin
      rd_req_c = !rd_pend_q && (gap_q == '0);
    end else if (state_q == READ && !rd_pend_q) begin
      if (!out_valid_q) begin
        rd_req_c  = 1'b1;
        rd_addr_c = AXW'(j_q) + AXW'(1);
      end else if (out_hs_c && !out_last_q) begin
        rd_req_c  = 1'b1;
        rd_addr_c = AXW'(j_q) + AXW'(2);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      j_q           <= '0;
      p_q           <= '0;
      gap_q         <= '0;
      rd_pend_q     <= 1'b0;
      start_ready_q <= 1'b0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      wready_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      job_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      job_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      wready_q   <= 1'b0;
      if (rd_req_c) begin
        rd_pend_q <= 1'b1;
      end else if (rd_ack_c) begin
        rd_pend_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          start_ready_q <= 1'b1;
          if (start_valid && start_ready_q) begin
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            wready_q      <= 1'b1;
            awaddr_q      <= AXW'(ADDR_CYCLES);
            wdata_q       <= {1'b0, start_cycles};
            state_q       <= WR_CYC;
          end
        end
        WR_CYC: begin
          k_q        <= '0;
          in_ready_q <= 1'b1;
          state_q    <= WR_DATA;
        end
        WR_DATA: begin
          if (in_valid && in_ready_q) begin
            wready_q <= 1'b1;
            awaddr_q <= AXW'(k_q) + AXW'(ADDR_DATA_BASE);
            wdata_q  <= {1'b0, in_data};
            k_q      <= k_q + KW'(1);
            if (k_q == KW'(NOPS - 1)) begin
              in_ready_q <= 1'b0;
              state_q    <= WR_START;
            end
          end
        end
        WR_START: begin
          wready_q <= 1'b1;
          awaddr_q <= AXW'(ADDR_STATUS);
          wdata_q  <= {1'b0, STATUS_START};
          p_q      <= '0;
          gap_q    <= '0;
          state_q  <= POLL;
        end
        POLL: begin
          if (gap_q != '0) gap_q <= gap_q - GW'(1);
          if (rd_ack_c) begin
            p_q <= p_q + PW'(1);
            if (rd_data_c[STATUS_DONE_BIT]) begin
              j_q     <= '0;
              state_q <= READ;
            end else if (p_q == PW'(MAX_POLLS - 1)) begin
              timeout_q     <= 1'b1;
              busy_q        <= 1'b0;
              start_ready_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              gap_q <= GW'(POLL_GAP - 1);
            end
          end
        end
        READ: begin
          if (rd_ack_c) begin
            out_data_q  <= rd_data_c;
            out_valid_q <= 1'b1;
            out_last_q  <= (j_q == JW'(NRES - 1));
          end
          if (out_hs_c) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              job_done_q    <= 1'b1;
              busy_q        <= 1'b0;
              start_ready_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              j_q <= j_q + JW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mxu_rd_port #(
    .READ_LAT (READ_LAT)
  ) u_rd_port (
    .clk       (clk),
    .reset     (reset),
    .req_i     (rd_req_c),
    .addr_i    (rd_addr_c),
    .arready_o (arready),
    .araddr_o  (araddr),
    .rready_o  (rready),
    .rdata_i   (rdata),
    .ack_c     (rd_ack_c),
    .data_c    (rd_data_c)
  );

  assign start_ready = start_ready_q;
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign wready      = wready_q;
  assign awaddr      = awaddr_q;
  assign wdata       = wdata_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign job_done    = job_done_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mxu_host_driver.sv
// Randomized bench for mxu_host_driver with a behavioural mxu slave and job-level reference.
module tb_mxu_host_driver;

  localparam int unsigned SIZE      = 2;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned POLL_GAP  = 4;
  localparam int unsigned MAX_POLLS = 4;
  localparam int unsigned NOPS      = 2 * SIZE * SIZE;
  localparam int unsigned NRES      = SIZE * SIZE;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid, start_ready;
  logic [7:0]  start_cycles;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, timeout, job_done;
  logic [31:0] awaddr, araddr, rdata;
  logic [8:0]  wdata;
  logic        wready, arready, rready;

  mxu_host_driver #(
    .SIZE(SIZE), .READ_LAT(READ_LAT), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready), .start_cycles(start_cycles),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .timeout(timeout), .job_done(job_done),
    .awaddr(awaddr), .wdata(wdata), .wready(wready),
    .araddr(araddr), .arready(arready), .rready(rready), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Job stimulus and model configuration
  logic [7:0]  ops [NOPS];
  logic [31:0] results [NRES];
  int stat_base = 0, done_after = 0, out_base = 0, stall_idx = -1, stall_len = 0;

  // Behavioural mxu slave: status answers "done" after done_after polls
  int          cyc = 0;
  int          stat_reads = 0;
  logic [31:0] last_addr = 32'd0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arready) begin
      last_addr <= araddr;
      if (araddr == 32'd0) stat_reads <= stat_reads + 1;
    end
  end

  always_comb begin
    rdata = 32'hDEAD_BEEF;
    if (rready) begin
      if (last_addr == 32'd0)
        rdata = ((stat_reads - stat_base) <= done_after) ? 32'h1 : 32'h2;
      else if (last_addr >= 32'd1 && last_addr <= 32'(NRES))
        rdata = results[last_addr - 32'd1];
    end
  end

  // Bus/stream monitor, sampled on the falling edge
  logic [31:0] wr_a[$], ar_a[$], o_d[$];
  logic [8:0]  wr_d[$];
  logic        o_l[$];
  int          wr_c[$], hs_c[$], ar_c[$], rr_c[$];
  int          n_done = 0, n_to = 0, viol = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_d;
  logic        prev_l;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (wready) begin wr_a.push_back(awaddr); wr_d.push_back(wdata); wr_c.push_back(cyc); end
      if (in_valid && in_ready) hs_c.push_back(cyc);
      if (arready) begin
        ar_a.push_back(araddr); ar_c.push_back(cyc);
        if (out_valid) viol++;
      end
      if (rready) rr_c.push_back(cyc);
      if (out_valid && out_ready) begin o_d.push_back(out_data); o_l.push_back(out_last); end
      if (job_done) n_done++;
      if (timeout) n_to++;
      if (stall_prev && (!out_valid || out_data !== prev_d || out_last !== prev_l)) viol++;
      stall_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  // Result consumer: random backpressure plus a forced stall on one chosen result
  initial begin : ready_drv
    int held;
    out_ready = 1'b0;
    held = 0;
    forever begin
      @(posedge clk); #1;
      if (!out_valid) held = 0;
      if (out_valid && (o_d.size() - out_base) == stall_idx && held < stall_len) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(3) != 0);
      end
    end
  end

  task automatic start_job(input logic [7:0] cyc_v);
    int budget;
    start_cycles = cyc_v;
    start_valid  = 1'b1;
    budget = 0;
    while (!start_ready && budget < 50) begin @(posedge clk); #1; budget++; end
    check("start_ready", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_cycles = ~cyc_v;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int budget;
    in_valid = 1'b1;
    in_data  = b;
    budget = 0;
    while (!in_ready && budget < 100) begin @(posedge clk); #1; budget++; end
    ok = (budget < 100);
    if (!ok) check("in_ready_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
  endtask

  // mode: 0 back-to-back, 1 valid/idle/idle pattern, 2 random gaps
  task automatic run_job(input logic [7:0] cyc_v, input int mode, input int da,
                         input int sidx, input int slen, input bit exp_to);
    int wb, hb, ab, rb, ob, db, tb0, vb, budget, n, nstat, nres, gap, last_wr, prev_stat;
    int exp_polls, exp_res;
    bit ok;
    wb = wr_a.size(); hb = hs_c.size(); ab = ar_a.size(); rb = rr_c.size();
    ob = o_d.size();  db = n_done;      tb0 = n_to;       vb = viol;
    stat_base = stat_reads; done_after = da; out_base = ob; stall_idx = sidx; stall_len = slen;

    start_job(cyc_v);
    for (int k = 0; k < NOPS; k++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(3));
      send_byte(ops[k], gap, ok);
      if (!ok) break;
    end
    start_valid = 1'b0;

    budget = 0;
    while (n_done == db && n_to == tb0 && budget < 3000) begin @(posedge clk); #1; budget++; end
    check("job_end_wait", 32'(budget < 3000), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_end", 32'(busy), 32'd0);
    check("start_ready_end", 32'(start_ready), 32'd1);

    // Write trace: cycles, every operand in order, then the start flag
    n = wr_a.size() - wb;
    check("wr_count", 32'(n), 32'(NOPS + 2));
    for (int i = 0; i < n && i < int'(NOPS + 2); i++) begin
      logic [31:0] ea;
      logic [8:0]  ed;
      if (i == 0) begin ea = 32'd1; ed = {1'b0, cyc_v}; end
      else if (i == int'(NOPS + 1)) begin ea = 32'd0; ed = 9'h001; end
      else begin ea = 32'(i + 1); ed = {1'b0, ops[i - 1]}; end
      check("wr_addr", wr_a[wb + i], ea);
      check("wr_data", 32'(wr_d[wb + i]), 32'(ed));
    end
    for (int k = 0; k < int'(NOPS) && (wb + 1 + k) < wr_c.size() && (hb + k) < hs_c.size(); k++)
      check("wr_follows_hs", 32'(wr_c[wb + 1 + k] - hs_c[hb + k]), 32'd1);
    last_wr = (n > 0) ? wr_c[wb + n - 1] : 0;

    // Reads: status polls first, then result addresses 1..NRES
    exp_polls = exp_to ? int'(MAX_POLLS) : da + 1;
    exp_res   = exp_to ? 0 : int'(NRES);
    nstat = 0; nres = 0; prev_stat = -1;
    for (int i = ab; i < ar_a.size(); i++) begin
      if (ar_a[i] == 32'd0 && nres == 0) begin
        if (prev_stat >= 0) check("poll_spacing", 32'(ar_c[i] - prev_stat), 32'(READ_LAT + POLL_GAP + 1));
        prev_stat = ar_c[i];
        nstat++;
      end else begin
        check("rd_addr", ar_a[i], 32'(nres + 1));
        nres++;
      end
    end
    check("n_polls", 32'(nstat), 32'(exp_polls));
    check("n_result_reads", 32'(nres), 32'(exp_res));
    if (ar_a.size() > ab) check("ar_after_start", 32'(ar_c[ab] > last_wr), 32'd1);
    check("rr_count", 32'(rr_c.size() - rb), 32'(ar_a.size() - ab));
    for (int i = 0; (ab + i) < ar_c.size() && (rb + i) < rr_c.size(); i++)
      check("rr_latency", 32'(rr_c[rb + i] - ar_c[ab + i]), 32'(READ_LAT));

    // Result stream
    check("out_count", 32'(o_d.size() - ob), 32'(exp_res));
    for (int i = 0; (ob + i) < o_d.size() && i < int'(NRES); i++) begin
      check("out_data", o_d[ob + i], results[i]);
      check("out_last", 32'(o_l[ob + i]), 32'(i == int'(NRES - 1)));
    end
    check("job_done_pulses", 32'(n_done - db), exp_to ? 32'd0 : 32'd1);
    check("timeout_pulses", 32'(n_to - tb0), exp_to ? 32'd1 : 32'd0);
    check("protocol", 32'(viol - vb), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus_w"}, {awaddr[22:0], wdata}, 32'd0);
    check({tag, "_bus_r"}, araddr, 32'd0);
    check({tag, "_strobes"}, {29'd0, wready, arready, rready}, 32'd0);
    check({tag, "_out"}, out_data, 32'd0);
    check({tag, "_flags"}, {24'd0, start_ready, in_ready, out_valid, out_last, busy, timeout, job_done, awaddr[31]}, 32'd0);
  endtask

  task automatic randomize_job();
    for (int i = 0; i < int'(NOPS); i++) ops[i] = 8'($urandom);
    for (int i = 0; i < int'(NRES); i++) results[i] = $urandom;
  endtask

  initial begin
    bit ok;
    reset = 1'b0; start_valid = 1'b0; start_cycles = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    #1 reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_start_ready", 32'(start_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < int'(NOPS); i++) ops[i] = 8'(i + 1);
    for (int i = 0; i < int'(NRES); i++) results[i] = 32'((i + 1) * 10);
    run_job(8'd7, 0, 3, -1, 0, 1'b0);
    run_job(8'd7, 1, 0, 1, 5, 1'b0);
    run_job(8'd9, 0, 1000, -1, 0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      randomize_job();
      run_job(8'($urandom), 2, int'($urandom_range(2)), int'($urandom_range(NRES - 1)),
              int'($urandom_range(6, 1)), 1'b0);
    end

    // Reset in the middle of the operand phase, then a clean job
    randomize_job();
    start_job(8'd5);
    for (int k = 0; k < 3; k++) send_byte(ops[k], 0, ok);
    in_valid = 1'b1; in_data = ops[3];
    #1 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    in_valid = 1'b0; start_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    run_job(8'd33, 2, 1, 2, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mxu_host_driver.md
Name: mxu_host_driver

Overview:
- Bus initiator that runs one complete matrix job on the mxu slave port.
- Accepts a job command (cycle count) and a byte stream of A then B (2*SIZE*SIZE bytes, row-major each).
- Writes the cycle count, the operand data and the start flag into the mxu cache, polls status until done, then reads SIZE*SIZE accumulator results and emits them on an output stream.
- Sits between the host/DMA side and mxu, driving mxu's awaddr/wdata/wready/araddr/arready/rready and sampling its rdata.

Parameters:
- SIZE, 4, systolic array dimension; must match the attached mxu.
- READ_LAT, 2, cycles from the arready pulse to the rdata sample point (the rready cycle).
- POLL_GAP, 4, idle cycles between status polls.
- MAX_POLLS, 1024, status polls allowed before the job is abandoned with timeout.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- start_valid  input  1  job request.
- start_ready  output  1  high only in IDLE.
- start_cycles  input  8  value written to cache[1].
- in_valid  input  1  operand byte valid.
- in_ready  output  1  operand byte accepted.
- in_data  input  8  operand byte.
- out_valid  output  1  result valid.
- out_ready  input  1  result accepted.
- out_data  output  32  accumulator result.
- out_last  output  1  marks the final result of the job.
- busy  output  1  high whenever not IDLE.
- timeout  output  1  one-cycle pulse when a job is abandoned.
- job_done  output  1  one-cycle pulse on the last result handshake.
- awaddr  output  32  mxu write address.
- wdata  output  9  mxu write data.
- wready  output  1  mxu write strobe.
- araddr  output  32  mxu read address.
- arready  output  1  mxu read-address strobe.
- rready  output  1  marks the rdata sample cycle.
- rdata  input  32  mxu read data.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE and all counters clear.
  - All outputs are 0, including awaddr and araddr.
  - No cleanup write is issued to mxu; the next job rewrites every cache location.
- All bus outputs are registered.
  - awaddr and wdata hold their last value while wready=0.
  - araddr holds its last value while arready=0.
- IDLE:
  - start_ready=1.
  - start_valid&start_ready captures start_cycles, then -> WR_CYC.
  - in_valid is ignored outside WR_DATA; start_valid is ignored when busy.
- WR_CYC: one cycle of wready=1, awaddr=1, wdata={1'b0,start_cycles}; then -> WR_DATA with k=0.
- WR_DATA:
  - in_ready=1.
  - Each handshake produces, next cycle, wready=1, awaddr=k+2, wdata={1'b0,in_data}; k then increments.
  - Gaps in in_valid give wready=0 cycles.
  - After handshake k=2*SIZE*SIZE-1 -> WR_START, with in_ready dropping in the same cycle.
- WR_START: one cycle of wready=1, awaddr=0, wdata=9'h001; then -> POLL with poll count p=0.
- POLL (status read sequence):
  - arready=1 for one cycle with araddr=0.
  - Wait READ_LAT-1 cycles.
  - One cycle of rready=1 samples rdata, and p increments.
  - If rdata[1]=1 -> READ with j=0.
  - Else if p==MAX_POLLS -> timeout pulse, then IDLE.
  - Otherwise wait POLL_GAP cycles and repeat.
  - The first arready comes no earlier than the cycle after the WR_START strobe, so the start write has landed and any stale done status has been overwritten.
- READ, for result index j:
  - arready pulse with araddr=j+1.
  - After READ_LAT cycles (the rready cycle), out_data<=rdata and out_valid=1 from the next cycle.
  - out_last=1 when j==SIZE*SIZE-1.
  - out_data, out_valid and out_last hold stable until out_ready; no new arready is issued while out_valid=1.
  - On the handshake: if last, pulse job_done and go to IDLE (out_valid=0); else j++ and the next read starts the following cycle.
- Widths:
  - k is sized for 2*SIZE*SIZE and j/p for their maxima; addresses are zero-extended to 32 bits.
  - Addresses never exceed 2*SIZE*SIZE+1.
- Simultaneous events:
  - start_valid during busy: ignored.
  - out_ready without out_valid: ignored.

Decomposition:
- Package mxu_pkg holds:
  - the state enum (IDLE, WR_CYC, WR_DATA, WR_START, POLL, READ);
  - ADDR_STATUS=0, ADDR_CYCLES=1, ADDR_DATA_BASE=2;
  - STATUS_START=8'h01 and STATUS_DONE_BIT=1.
- One sub-module, mxu_rd_port:
  - Given req and addr, it issues the arready pulse, counts READ_LAT, asserts rready, and returns ack plus captured data.
  - It is shared by the POLL and READ states.

Test Plan:
- SIZE=2, start_cycles=7, bytes 1..8 streamed back-to-back -> write trace (1,7),(2,1),(3,2)...(9,8),(0,0x001), with one strobe per cycle.
- in_valid toggling 1,0,0,1... -> same address/data trace, and wready low in the gap cycles.
- mxu model returns status 0x01 for 3 polls, then 0x02 -> exactly 4 status reads spaced POLL_GAP apart, then reads at araddr 1..4 emitting 10,20,30,40 with out_last on 40 and a job_done pulse.
- out_ready held low 5 cycles on result 2 -> out_data stable, no arready until the handshake; order is preserved.
- MAX_POLLS=4 and status never done -> 4 polls, a timeout pulse, IDLE, no result reads.
- reset asserted mid WR_DATA (k=3) -> outputs 0 immediately; a new job afterwards produces the full trace starting at awaddr=1.
